// File: rtl/avmm_input_capture.sv
// Avalon-MM input capture: synchronised pins, W1C rising-edge capture, saturating edge-event counter, masked level irq.
// Reads return READ_LATENCY cycles after acceptance; no backpressure, waitrequest is tied low and every request completes.
module avmm_input_capture #(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             avs_waitrequest,
    output logic             irq
);

    localparam logic [1:0] REG_DATA      = 2'd0;
    localparam logic [1:0] REG_IRQ_MASK  = 2'd1;
    localparam logic [1:0] REG_EDGE_CAP  = 2'd2;
    localparam logic [1:0] REG_EVENT_CNT = 2'd3;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      event_cnt_q;

    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;
    logic             wr_cnt;
    logic [31:0]      rd_data;

    logic             rd_vld_q [READ_LATENCY];
    logic [31:0]      rd_dat_q [READ_LATENCY];

    wire unused_wdata = ^avs_writedata;

    assign avs_waitrequest = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;

    // A read in the same cycle as a write wins; the write is dropped.
    assign wr_en   = avs_write & ~avs_read;
    assign wr_mask = wr_en && (avs_address == REG_IRQ_MASK);
    assign wr_cap  = wr_en && (avs_address == REG_EDGE_CAP);
    assign wr_cnt  = wr_en && (avs_address == REG_EVENT_CNT);
    assign cap_clr = wr_cap ? avs_writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            event_cnt_q <= '0;
            irq         <= 1'b0;
        end else begin
            prev_q <= sync_q;
            if (wr_mask) begin
                irq_mask_q <= avs_writedata[WIDTH-1:0];
            end
            // New edges are OR-ed in after the clear so a coincident edge survives.
            edge_cap_q <= (edge_cap_q & ~cap_clr) | rise;
            if (wr_cnt) begin
                event_cnt_q <= '0;
            end else if ((|rise) && (event_cnt_q != 32'hFFFF_FFFF)) begin
                event_cnt_q <= event_cnt_q + 32'd1;
            end
            irq <= |(edge_cap_q & irq_mask_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (avs_address)
            REG_DATA:      rd_data = 32'(sync_q);
            REG_IRQ_MASK:  rd_data = 32'(irq_mask_q);
            REG_EDGE_CAP:  rd_data = 32'(edge_cap_q);
            REG_EVENT_CNT: rd_data = event_cnt_q;
            default:       rd_data = '0;
        endcase
    end

    // Snapshot is taken from pre-update state, so a read sees the register before any same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= 1'b0;
                rd_dat_q[i] <= '0;
            end
        end else begin
            rd_vld_q[0] <= avs_read;
            rd_dat_q[0] <= avs_read ? rd_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dat_q[i] <= rd_dat_q[i-1];
            end
        end
    end

    assign avs_readdatavalid = rd_vld_q[READ_LATENCY-1];
    assign avs_readdata      = rd_vld_q[READ_LATENCY-1] ? rd_dat_q[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_avmm_input_capture.sv
// Directed bench for avmm_input_capture with a per-cycle reference model of the register map and read pipe.
module tb_avmm_input_capture;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] gpio_in;
    logic [1:0]   avs_address;
    logic         avs_read;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         avs_waitrequest;
    logic         irq;

    avmm_input_capture #(.WIDTH(W), .SYNC_STAGES(SS), .READ_LATENCY(LAT)) dut (
        .clk               (clk),
        .reset             (reset),
        .gpio_in           (gpio_in),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] dat;
    } rsp_t;

    rsp_t         rq[$];
    logic [W-1:0] hist[$];
    int           cyc    = 0;
    logic [W-1:0] m_sync = '0;
    logic [W-1:0] m_prev = '0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap  = '0;
    logic [31:0]  m_cnt  = '0;
    logic         m_irq  = 1'b0;
    logic         bd_req = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] rise;
        logic [W-1:0] clr;
        logic [31:0]  rdv;
        logic         wr;
        cyc++;
        if (reset) begin
            rq.delete();
            hist.delete();
            for (int i = 0; i < SS - 1; i++) hist.push_back('0);
            m_sync = '0; m_prev = '0; m_mask = '0; m_cap = '0; m_cnt = '0; m_irq = 1'b0;
        end else begin
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            rise = m_sync & ~m_prev;
            if (avs_read) begin
                case (avs_address)
                    2'd0:    rdv = {{(32-W){1'b0}}, m_sync};
                    2'd1:    rdv = {{(32-W){1'b0}}, m_mask};
                    2'd2:    rdv = {{(32-W){1'b0}}, m_cap};
                    default: rdv = m_cnt;
                endcase
                rq.push_back('{cyc + LAT - 1, rdv});
            end
            wr    = avs_write && !avs_read;
            m_irq = |(m_cap & m_mask);
            if (wr && avs_address == 2'd1) m_mask = avs_writedata[W-1:0];
            clr   = (wr && avs_address == 2'd2) ? avs_writedata[W-1:0] : '0;
            m_cap = (m_cap & ~clr) | rise;
            if (bd_req)                         m_cnt = 32'hFFFF_FFFE;
            else if (wr && avs_address == 2'd3) m_cnt = 32'd0;
            else if (rise != '0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_prev = m_sync;
            hist.push_back(gpio_in);
            m_sync = hist.pop_front();
        end
    end

    always @(posedge clk) begin
        logic        exp_v;
        logic [31:0] exp_d;
        #1;
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        exp_d = exp_v ? rq[0].dat : 32'd0;
        chk("cyc_readdatavalid", 32'(avs_readdatavalid), 32'(exp_v));
        chk("cyc_readdata", avs_readdata, exp_d);
        chk("cyc_irq", 32'(irq), 32'(m_irq));
        chk("cyc_waitrequest", 32'(avs_waitrequest), 32'd0);
    end

    // ---------------- bus tasks (called at a falling edge) ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        int          lat = -1;
        logic [31:0] got = '0;
        avs_address = a;
        avs_read    = 1'b1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(posedge clk); #1;
            avs_read = 1'b0;
            if (avs_readdatavalid) begin
                lat = i + 1;
                got = avs_readdata;
            end
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no readdatavalid within 10 cycles, expected data 0x%08h", name, exp);
        end else begin
            chk(name, got, exp);
            chk({name, "_latency"}, lat, LAT);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] got[$];
        int          first;
        int          last;
        int          nv;

        reset = 1'b1; gpio_in = '0; avs_address = '0; avs_read = 1'b0;
        avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("irq_after_reset", 32'(irq), 32'd0);
        rd_chk("data_after_reset", 2'd0, 32'h0000_0000);

        gpio_in = 8'hA5;
        repeat (4) @(negedge clk);
        rd_chk("data_a5", 2'd0, 32'h0000_00A5);
        rd_chk("cap_a5", 2'd2, 32'h0000_00A5);
        rd_chk("cnt_one", 2'd3, 32'd1);
        chk("irq_masked", 32'(irq), 32'd0);

        wr(2'd1, 32'h0000_0001);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'd1);
        @(negedge clk);
        wr(2'd2, 32'h0000_0001);
        chk("irq_still_high", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_cleared", 32'(irq), 32'd0);
        @(negedge clk);
        rd_chk("cap_a4", 2'd2, 32'h0000_00A4);

        // Rising edge of bit 3 reaches the capture register in the same cycle as its W1C.
        gpio_in = 8'hAD;
        repeat (2) @(negedge clk);
        wr(2'd2, 32'h0000_0008);
        rd_chk("cap_set_wins", 2'd2, 32'h0000_00AC);
        rd_chk("cnt_two", 2'd3, 32'd2);

        gpio_in = 8'hBD;
        repeat (2) @(negedge clk);
        wr(2'd3, 32'h0000_0000);
        rd_chk("cnt_clear_wins", 2'd3, 32'd0);
        rd_chk("cap_bc", 2'd2, 32'h0000_00BC);

        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("data_read_only", 2'd0, 32'h0000_00BD);

        avs_address = 2'd1; avs_writedata = 32'h0000_00FF;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        rd_chk("mask_write_dropped", 2'd1, 32'h0000_0001);

        got.delete(); first = -1; last = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                avs_address = 2'(c);
                avs_read    = 1'b1;
            end else begin
                avs_read    = 1'b0;
            end
            @(posedge clk); #1;
            if (avs_readdatavalid) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(avs_readdata);
            end
            @(negedge clk);
        end
        chk("b2b_count", got.size(), 4);
        chk("b2b_first", first, LAT - 1);
        chk("b2b_contiguous", last - first, 3);
        if (got.size() == 4) begin
            chk("b2b_d0", got[0], 32'h0000_00BD);
            chk("b2b_d1", got[1], 32'h0000_0001);
            chk("b2b_d2", got[2], 32'h0000_00BC);
            chk("b2b_d3", got[3], 32'h0000_0000);
        end

        avs_address = 2'd0;
        avs_read    = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1; gpio_in = '0; avs_read = 1'b0;
        nv = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (avs_readdatavalid) nv++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (avs_readdatavalid) nv++;
        end
        @(negedge clk);
        chk("no_valid_after_reset", nv, 0);
        rd_chk("rst_data", 2'd0, 32'd0);
        rd_chk("rst_mask", 2'd1, 32'd0);
        rd_chk("rst_cap", 2'd2, 32'd0);
        rd_chk("rst_cnt", 2'd3, 32'd0);

        force dut.event_cnt_q = 32'hFFFF_FFFE;
        bd_req = 1'b1;
        @(negedge clk);
        release dut.event_cnt_q;
        bd_req = 1'b0;
        rd_chk("cnt_preload", 2'd3, 32'hFFFF_FFFE);
        gpio_in = 8'h01; repeat (3) @(negedge clk);
        gpio_in = 8'h00; repeat (3) @(negedge clk);
        rd_chk("cnt_max", 2'd3, 32'hFFFF_FFFF);
        repeat (2) begin
            gpio_in = 8'h01; repeat (3) @(negedge clk);
            gpio_in = 8'h00; repeat (3) @(negedge clk);
        end
        rd_chk("cnt_saturated", 2'd3, 32'hFFFF_FFFF);
        rd_chk("cap_bit0", 2'd2, 32'h0000_0001);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
